// File: rtl/cla_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t     : sequencer states (IDLE, ADD, DONE)
//   WIDTH       : operand/result width
//   NIBBLE      : width of one CLA slice
//   NUM_NIBBLES : slices processed per operation
package cla_pkg;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned NIBBLE      = 4;
  localparam int unsigned NUM_NIBBLES = WIDTH / NIBBLE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(NUM_NIBBLES - 1);

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
//   a, b   : nibble operands
//   c0     : carry in
//   s      : nibble sum
//   c4     : carry out of bit 3
//   p4     : group propagate
//   g4_inv : group generate, active low
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              c0,
  output logic [NIBBLE-1:0] s,
  output logic              c4,
  output logic              p4,
  output logic              g4_inv
);

  logic [NIBBLE-1:0] p;
  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] c;
  logic              g4;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign g4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign p4 = &p;

  assign c4     = g4 | (p4 & c0);
  assign g4_inv = ~g4;
  assign s      = p ^ c;

endmodule

// File: rtl/nibble_add_seq.sv
// 16-bit adder built from one CLA nibble slice reused over four cycles, LSB nibble first.
//   clk, rst        : clock, asynchronous active-high reset
//   start, a, b, cin: request and operands, captured when accepted in IDLE or DONE
//   busy            : nibble additions in progress
//   done            : one-cycle result-valid pulse
//   sum, cout, ovf  : result, carry out of bit 15, signed overflow; held until next op writes
module nibble_add_seq
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  state_t            state_q, state_d;
  idx_t              idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [3:0]        bit_ofs;
  logic [NIBBLE-1:0] a_nib, b_nib, s_nib;
  logic              c4, p4, g4_inv;
  logic              c_into_msb;

  assign bit_ofs = {idx_q, 2'b00};
  assign a_nib   = a_q[bit_ofs +: NIBBLE];
  assign b_nib   = b_q[bit_ofs +: NIBBLE];

  cla4_slice u_slice (
    .a      (a_nib),
    .b      (b_nib),
    .c0     (carry_q),
    .s      (s_nib),
    .c4     (c4),
    .p4     (p4),
    .g4_inv (g4_inv)
  );

  // Carry into the top bit of the nibble, recovered from s = a ^ b ^ c.
  assign c_into_msb = a_nib[NIBBLE-1] ^ b_nib[NIBBLE-1] ^ s_nib[NIBBLE-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ADD;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[bit_ofs +: NIBBLE] = s_nib;
        carry_d                  = c4;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = c4;
          ovf_d   = c_into_msb ^ c4;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ADD);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // Lookahead group terms must agree with the ripple carry out of the slice.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == ADD) |-> (c4 == (~g4_inv | (p4 & carry_q))));

  assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule

// File: tb/tb_nibble_add_seq.sv
module tb_nibble_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int pass_cnt;
  int total_cnt;

  nibble_add_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain 17-bit arithmetic and sign rules.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic c);
    logic [16:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {16'h0, c};
    v = (x[15] == y[15]) && (t[15] != x[15]);
    return {v, t};
  endfunction

  // Called at a negedge: present a request, let one rising edge take it, then scramble inputs.
  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic c);
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    cin   = 1'($urandom);
  endtask

  // Bounded wait for done, sampled on negedges; busy must be high every cycle before it.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (busy && done) busy_ok = 1'b0;
      if (done) begin
        cyc = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    cin   = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, sum, cout, ovf} !== 20'h0)
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [15:0] va [5] = '{16'h0000, 16'h000F, 16'hFFFF, 16'h7FFF, 16'hA5A5};
    logic [15:0] vb [5] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h5A5A};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [17:0] want [5] = '{{2'b00, 16'h0000}, {2'b00, 16'h0010}, {2'b01, 16'h0000},
                              {2'b10, 16'h8000}, {2'b01, 16'h0000}};
    int cyc;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc != 5 || !bok)
        $display("FAIL directed_latency[%0d]: got done at cycle %0d busy_ok=%0d, want 5 1",
                 i, cyc, bok);
      else pass_cnt++;
      total_cnt++;
      if ({ovf, cout, sum} !== want[i])
        $display("FAIL directed_result[%0d]: got ovf=%b cout=%b sum=%h, want %h",
                 i, ovf, cout, sum, want[i]);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({ovf, cout, sum} !== want[i] || done !== 1'b0)
        $display("FAIL directed_hold[%0d]: got ovf=%b cout=%b sum=%h done=%b, want %h 0",
                 i, ovf, cout, sum, done, want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    int cyc;
    bit bok;
    launch(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bok);
    total_cnt++;
    if (cyc != 3 || !bok)
      $display("FAIL ignore_latency: got done at cycle %0d busy_ok=%0d, want 3 1", cyc, bok);
    else pass_cnt++;
    total_cnt++;
    if ({cout, sum} !== 17'h02345)
      $display("FAIL ignore_result: got cout=%b sum=%h, want 0 2345", cout, sum);
    else pass_cnt++;
    // Still in the DONE cycle: chain the next request with no bubble.
    launch(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b10)
      $display("FAIL b2b_busy: got busy=%b done=%b, want 1 0", busy, done);
    else pass_cnt++;
    wait_done(cyc, bok);
    total_cnt++;
    if (cyc != 4 || !bok || {cout, sum} !== 17'h00002)
      $display("FAIL b2b_result: got cyc=%0d busy_ok=%0d cout=%b sum=%h, want 4 1 0 0002",
               cyc, bok, cout, sum);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit bok;
    bit saw_done;
    launch(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, sum, cout, ovf} !== 20'h0)
      $display("FAIL abort_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    else pass_cnt++;
    @(negedge clk);
    rst      = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done)
      $display("FAIL abort_no_done: got activity after abort=1, want 0");
    else pass_cnt++;
    launch(16'h000A, 16'h0007, 1'b1);
    wait_done(cyc, bok);
    total_cnt++;
    if (cyc != 5 || !bok || {cout, sum} !== 17'h00012)
      $display("FAIL after_abort: got cyc=%0d busy_ok=%0d cout=%b sum=%h, want 5 1 0 0012",
               cyc, bok, cout, sum);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        c;
    logic [17:0] want;
    int          cyc;
    bit          bok;
    for (int i = 0; i < 40; i++) begin
      x    = 16'($urandom);
      y    = 16'($urandom);
      c    = 1'($urandom);
      want = ref_add(x, y, c);
      launch(x, y, c);
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc != 5 || !bok || {ovf, cout, sum} !== want)
        $display("FAIL random[%0d] %h+%h+%b: got cyc=%0d busy_ok=%0d ovf=%b cout=%b sum=%h, want 5 1 %h",
                 i, x, y, c, cyc, bok, ovf, cout, sum, want);
      else pass_cnt++;
      // Sometimes chain directly from DONE, otherwise idle a little and confirm hold.
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
        total_cnt++;
        if ({ovf, cout, sum} !== want)
          $display("FAIL random_hold[%0d]: got ovf=%b cout=%b sum=%h, want %h",
                   i, ovf, cout, sum, want);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_ignore_and_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
